// File: rtl/regfile_sb_pkg.sv
// rv_pkg: shared register-file widths and types for the RV32IM core.
// rd_busy/rsN_busy: busy[idx] of a pending M-unit result, gated by read enable for rsN.
package rv_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREGS_DEF = 32;
  typedef logic [$clog2(NREGS_DEF)-1:0] reg_idx_t;
  typedef logic [XLEN_DEF-1:0] xword_t;
endpackage

// File: rtl/regfile_sb_scoreboard.sv
// regfile_scoreboard: busy bits, pending count and hazard outputs for M-unit results.
// REGFILE_BYPASS_EN masks hazards retired by port B in the same cycle.
module regfile_scoreboard
  import rv_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int AW = $clog2(NREGS),
  parameter int PW = $clog2(NREGS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          issue_en,
  input  logic [AW-1:0] issue_rd,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_rd,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  input  logic          rs1_rd_en,
  input  logic          rs2_rd_en,
  output logic          rs1_busy,
  output logic          rs2_busy,
  output logic          rd_busy,
  output logic [PW-1:0] pending,
  output logic [NREGS-1:0] busy
);
  logic [NREGS-1:0] busy_q, busy_d;
  logic [PW-1:0] pending_q, pending_d;
  logic set_new, clr_old, m1, m2, mr;
  always_comb begin
    set_new = issue_en && issue_rd != '0 && !busy_q[issue_rd];
    clr_old = wb_en && wb_rd != '0 && busy_q[wb_rd] && !(issue_en && issue_rd == wb_rd);
    busy_d = busy_q;
    if (wb_en) busy_d[wb_rd] = 1'b0;
    if (issue_en) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
    pending_d = pending_q + PW'(set_new) - PW'(clr_old);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      busy_q <= '0;
      pending_q <= '0;
    end else begin
      busy_q <= busy_d;
      pending_q <= pending_d;
    end
`ifdef REGFILE_BYPASS_EN
  assign m1 = wb_en && wb_rd == rs1;
  assign m2 = wb_en && wb_rd == rs2;
  assign mr = wb_en && wb_rd == issue_rd;
`else
  assign m1 = 1'b0;
  assign m2 = 1'b0;
  assign mr = 1'b0;
`endif
  assign rs1_busy = busy_q[rs1] && rs1_rd_en && !m1;
  assign rs2_busy = busy_q[rs2] && rs2_rd_en && !m2;
  assign rd_busy = busy_q[issue_rd] && !mr;
  assign pending = pending_q;
  assign busy = busy_q;
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: two-read/two-write register file with write-back scoreboard.
// REGFILE_BYPASS_EN enables same-cycle write forwarding (port B over port A).
module regfile_sb
  import rv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  localparam int AW = $clog2(NREGS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [AW-1:0]              rs1,
  input  logic [AW-1:0]              rs2,
  input  logic                       rs1_rd_en,
  input  logic                       rs2_rd_en,
  output logic [XLEN-1:0]            rS1,
  output logic [XLEN-1:0]            rS2,
  input  logic                       wa_en,
  input  logic [AW-1:0]              wa_rd,
  input  logic [XLEN-1:0]            wa_data,
  input  logic                       wb_en,
  input  logic [AW-1:0]              wb_rd,
  input  logic [XLEN-1:0]            wb_data,
  input  logic                       issue_en,
  input  logic [AW-1:0]              issue_rd,
  output logic                       rs1_busy,
  output logic                       rs2_busy,
  output logic                       rd_busy,
  output logic [$clog2(NREGS+1)-1:0] pending,
  output logic                       collision_err
);
  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [NREGS-1:0] busy;
  logic collision_q, collision_d, wa_ok, wb_ok;
  regfile_scoreboard #(.NREGS(NREGS)) u_sb (
    .clk(clk), .rst_n(rst_n), .issue_en(issue_en), .issue_rd(issue_rd),
    .wb_en(wb_en), .wb_rd(wb_rd), .rs1(rs1), .rs2(rs2),
    .rs1_rd_en(rs1_rd_en), .rs2_rd_en(rs2_rd_en), .rs1_busy(rs1_busy),
    .rs2_busy(rs2_busy), .rd_busy(rd_busy), .pending(pending), .busy(busy)
  );
  always_comb begin
    wa_ok = wa_en && wa_rd != '0;
    wb_ok = wb_en && wb_rd != '0;
    regs_d = regs_q;
    if (wa_ok) regs_d[wa_rd] = wa_data;
    if (wb_ok) regs_d[wb_rd] = wb_data;
    regs_d[0] = '0;
    collision_d = collision_q || (wa_ok && (busy[wa_rd] || (wb_ok && wb_rd == wa_rd)));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      collision_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      collision_q <= collision_d;
    end
`ifdef REGFILE_BYPASS_EN
  assign rS1 = !rs1_rd_en ? '0 : (wb_ok && wb_rd == rs1) ? wb_data :
               (wa_ok && wa_rd == rs1) ? wa_data : regs_q[rs1];
  assign rS2 = !rs2_rd_en ? '0 : (wb_ok && wb_rd == rs2) ? wb_data :
               (wa_ok && wa_rd == rs2) ? wa_data : regs_q[rs2];
`else
  assign rS1 = rs1_rd_en ? regs_q[rs1] : '0;
  assign rS2 = rs2_rd_en ? regs_q[rs2] : '0;
`endif
  assign collision_err = collision_q;
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed self-checking bench for regfile_sb.
module tb_regfile_sb;
  logic clk = 0, rst_n = 0;
  logic [4:0] rs1, rs2, wa_rd, wb_rd, issue_rd;
  logic rs1_rd_en, rs2_rd_en, wa_en, wb_en, issue_en;
  logic [31:0] wa_data, wb_data, rS1, rS2;
  logic rs1_busy, rs2_busy, rd_busy, collision_err;
  logic [5:0] pending;
  int tests = 0, fails = 0;

  regfile_sb dut (
    .clk(clk), .rst_n(rst_n), .rs1(rs1), .rs2(rs2), .rs1_rd_en(rs1_rd_en),
    .rs2_rd_en(rs2_rd_en), .rS1(rS1), .rS2(rS2), .wa_en(wa_en), .wa_rd(wa_rd),
    .wa_data(wa_data), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .issue_en(issue_en), .issue_rd(issue_rd), .rs1_busy(rs1_busy),
    .rs2_busy(rs2_busy), .rd_busy(rd_busy), .pending(pending),
    .collision_err(collision_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wa_en = 0; wb_en = 0; issue_en = 0;
    wa_rd = 0; wb_rd = 0; issue_rd = 0;
    wa_data = 0; wb_data = 0;
  endtask

  task automatic test_reset();
    rst_n = 1;
    idle();
    rs1 = 0; rs2 = 0; rs1_rd_en = 1; rs2_rd_en = 1;
    tick();
    wa_en = 1; wa_rd = 5; wa_data = 32'h5555_AAAA;
    issue_en = 1; issue_rd = 6;
    tick();
    idle();
    #2 rst_n = 0;
    #2 rst_n = 1;
    rs1 = 5; rs2 = 6;
    #1;
    tests++;
    if (rS1 !== 0 || rS2 !== 0) begin fails++; $display("FAIL reset_reads rS1=%h rS2=%h want 0", rS1, rS2); end
    tests++;
    if (rs1_busy !== 0 || rs2_busy !== 0 || pending !== 0 || collision_err !== 0) begin
      fails++; $display("FAIL reset_sb busy=%b%b pending=%0d coll=%b want 0", rs1_busy, rs2_busy, pending, collision_err);
    end
  endtask

  task automatic test_write_read();
    wa_en = 1; wa_rd = 5; wa_data = 32'hDEADBEEF; rs1 = 5;
    tick();
    idle();
    tests++;
    if (rS1 !== 32'hDEADBEEF) begin fails++; $display("FAIL write_x5 rS1=%h want deadbeef", rS1); end
    rs1_rd_en = 0;
    #1;
    tests++;
    if (rS1 !== 0) begin fails++; $display("FAIL rd_en_low rS1=%h want 0", rS1); end
    rs1_rd_en = 1;
  endtask

  task automatic test_x0();
    wa_en = 1; wa_rd = 0; wa_data = 32'h1234;
    wb_en = 1; wb_rd = 0; wb_data = 32'h5678;
    issue_en = 1; issue_rd = 0; rs1 = 0;
    tick();
    idle();
    tests++;
    if (rS1 !== 0 || pending !== 0 || collision_err !== 0) begin
      fails++; $display("FAIL x0 rS1=%h pending=%0d coll=%b want 0", rS1, pending, collision_err);
    end
  endtask

  task automatic test_scoreboard();
    issue_en = 1; issue_rd = 7; rs2 = 7;
    tick();
    idle();
    tests++;
    if (rs2_busy !== 1 || pending !== 1) begin fails++; $display("FAIL issue7 busy=%b pending=%0d want 1/1", rs2_busy, pending); end
    issue_rd = 7;
    #1;
    tests++;
    if (rd_busy !== 1) begin fails++; $display("FAIL rd_busy7 got %b want 1", rd_busy); end
    wb_en = 1; wb_rd = 7; wb_data = 32'h12;
    tick();
    idle();
    tests++;
    if (rs2_busy !== 0 || pending !== 0 || rS2 !== 32'h12) begin
      fails++; $display("FAIL retire7 busy=%b pending=%0d rS2=%h want 0/0/12", rs2_busy, pending, rS2);
    end
  endtask

  task automatic test_set_clear_same();
    issue_en = 1; issue_rd = 9;
    tick();
    issue_en = 1; issue_rd = 9; wb_en = 1; wb_rd = 9; wb_data = 32'h99;
    tick();
    idle();
    rs1 = 9;
    #1;
    tests++;
    if (rs1_busy !== 1 || pending !== 1) begin fails++; $display("FAIL set_wins busy=%b pending=%0d want 1/1", rs1_busy, pending); end
    wb_en = 1; wb_rd = 9; wb_data = 32'h9A;
    tick();
    idle();
    tests++;
    if (rs1_busy !== 0 || pending !== 0 || rS1 !== 32'h9A) begin
      fails++; $display("FAIL retire9 busy=%b pending=%0d rS1=%h want 0/0/9a", rs1_busy, pending, rS1);
    end
  endtask

  task automatic test_collision();
    wa_en = 1; wa_rd = 3; wa_data = 32'h1;
    wb_en = 1; wb_rd = 3; wb_data = 32'h2;
    rs1 = 3;
    tick();
    idle();
    tests++;
    if (rS1 !== 32'h2 || collision_err !== 1) begin fails++; $display("FAIL collide x3=%h coll=%b want 2/1", rS1, collision_err); end
    tick();
    tick();
    tests++;
    if (collision_err !== 1) begin fails++; $display("FAIL coll_sticky got %b want 1", collision_err); end
    #2 rst_n = 0;
    #2 rst_n = 1;
    #1;
    tests++;
    if (collision_err !== 0) begin fails++; $display("FAIL coll_clear got %b want 0", collision_err); end
    issue_en = 1; issue_rd = 11;
    tick();
    idle();
    wa_en = 1; wa_rd = 11; wa_data = 32'h77; rs2 = 11;
    tick();
    idle();
    tests++;
    if (collision_err !== 1 || rS2 !== 32'h77 || rs2_busy !== 1) begin
      fails++; $display("FAIL wa_busy coll=%b rS2=%h busy=%b want 1/77/1", collision_err, rS2, rs2_busy);
    end
    #2 rst_n = 0;
    #2 rst_n = 1;
  endtask

  task automatic test_bypass();
    issue_en = 1; issue_rd = 4;
    tick();
    idle();
    wb_en = 1; wb_rd = 4; wb_data = 32'hAA; rs1 = 4; issue_rd = 4;
    #1;
`ifdef REGFILE_BYPASS_EN
    tests++;
    if (rS1 !== 32'hAA || rs1_busy !== 0 || rd_busy !== 0) begin
      fails++; $display("FAIL bypass rS1=%h busy=%b rd_busy=%b want aa/0/0", rS1, rs1_busy, rd_busy);
    end
`else
    tests++;
    if (rS1 !== 0 || rs1_busy !== 1 || rd_busy !== 1) begin
      fails++; $display("FAIL no_bypass rS1=%h busy=%b rd_busy=%b want 0/1/1", rS1, rs1_busy, rd_busy);
    end
`endif
    tick();
    idle();
    tests++;
    if (rS1 !== 32'hAA || rs1_busy !== 0 || pending !== 0) begin
      fails++; $display("FAIL after_wb4 rS1=%h busy=%b pending=%0d want aa/0/0", rS1, rs1_busy, pending);
    end
  endtask

  task automatic test_fill_reset();
    for (int i = 1; i < 32; i++) begin
      issue_en = 1; issue_rd = 5'(i);
      tick();
    end
    idle();
    rs1 = 31; rs2 = 1;
    #1;
    tests++;
    if (pending !== 31 || rs1_busy !== 1 || rs2_busy !== 1) begin
      fails++; $display("FAIL fill pending=%0d busy=%b%b want 31/11", pending, rs1_busy, rs2_busy);
    end
    rst_n = 0;
    #1;
    tests++;
    if (pending !== 0 || rs1_busy !== 0 || rs2_busy !== 0) begin
      fails++; $display("FAIL async_rst pending=%0d busy=%b%b want 0/00", pending, rs1_busy, rs2_busy);
    end
    rst_n = 1;
  endtask

  initial begin
    idle();
    rs1 = 0; rs2 = 0; rs1_rd_en = 1; rs2_rd_en = 1;
    test_reset();
    test_write_read();
    test_x0();
    test_scoreboard();
    test_set_clear_same();
    test_collision();
    test_bypass();
    test_fill_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
